// File: rtl/ysyx_22040383_hazard_ctrl.sv
// ysyx_22040383_hazard_ctrl: central stall/flush controller; define YSYX_22040383_MDU_EN to enable MDU occupancy tracking
module ysyx_22040383_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_ren,
    input  logic             id_rs2_ren,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rd_wen,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             stall_pc,
    output logic             stall_id_reg,
    output logic             invalid,
    output logic             stall_ex_reg,
    output logic             flush_ex_reg,
    output logic             stall_mem_reg,
    output logic             flush_mem_reg,
    output logic             flush_wb_reg,
    output logic             mem_timeout
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(MEM_TIMEOUT);

    logic             mem_stall, mdu_stall, load_use, redirect;
    logic             stall_ex, stall_id, flush_ex, flush_mem, pc_hold, bubble_id;
    logic             drop_pending_q, drop_pending_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

`ifdef YSYX_22040383_MDU_EN
    logic mdu_busy_q, mdu_busy_d;

    // Busy covers the cycles between launch and result; a same-cycle done leaves it clear
    always_comb begin
        mdu_busy_d = mdu_busy_q;
        if (mdu_done)
            mdu_busy_d = 1'b0;
        else if (mdu_start)
            mdu_busy_d = 1'b1;
    end

    // MDU occupancy register
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            mdu_busy_q <= 1'b0;
        else
            mdu_busy_q <= mdu_busy_d;
    end

    assign mdu_stall = (mdu_start | mdu_busy_q) & ~mdu_done;
`else
    logic unused_mdu;
    assign unused_mdu = mdu_start ^ mdu_done;
    assign mdu_stall  = 1'b0;
`endif

    // Hazard terms and the prioritised hold/bubble network; holds always beat bubbles
    always_comb begin
        mem_stall = dmem_req & ~dmem_ready;
        load_use  = ex_is_load & ex_rd_wen & (ex_rd != '0) &
                    ((id_rs1_ren & (id_rs1 == ex_rd)) | (id_rs2_ren & (id_rs2 == ex_rd)));
        stall_ex  = mem_stall | mdu_stall;
        flush_mem = mdu_stall & ~mem_stall;
        redirect  = ex_branch_taken & ~stall_ex;
        stall_id  = stall_ex | (load_use & ~redirect);
        flush_ex  = ~stall_ex & (redirect | load_use);
        pc_hold   = stall_id | (~imem_ready & ~redirect);
        bubble_id = ~stall_id & (redirect | ~imem_ready | drop_pending_q);
    end

    // Wrong-path tracking and memory watchdog next state
    always_comb begin
        drop_pending_d = drop_pending_q;
        if (redirect & ~imem_ready)
            drop_pending_d = 1'b1;
        else if (imem_ready & ~stall_id & ~redirect)
            drop_pending_d = 1'b0;
        wd_cnt_d      = mem_stall ? ((wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + CNT_W'(1)) : '0;
        mem_timeout_d = mem_timeout_q | (wd_cnt_d == WD_MAX);
    end

    // State registers, all cleared by reset including mid-wait
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drop_pending_q <= 1'b0;
            wd_cnt_q       <= '0;
            mem_timeout_q  <= 1'b0;
        end else begin
            drop_pending_q <= drop_pending_d;
            wd_cnt_q       <= wd_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign stall_pc      = ~sys_rst & pc_hold;
    assign stall_id_reg  = ~sys_rst & stall_id;
    assign invalid       = ~sys_rst & bubble_id;
    assign stall_ex_reg  = ~sys_rst & stall_ex;
    assign flush_ex_reg  = ~sys_rst & flush_ex;
    assign stall_mem_reg = ~sys_rst & mem_stall;
    assign flush_mem_reg = ~sys_rst & flush_mem;
    assign flush_wb_reg  = ~sys_rst & mem_stall;
    assign mem_timeout   = ~sys_rst & mem_timeout_q;
endmodule

// File: doc/ysyx_22040383_hazard_ctrl.md
# ysyx_22040383_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It takes hazard and handshake status from the IF, ID, EX and MEM stages and drives the hold and bubble inputs of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC hold. It handles load-use interlock, branch redirect squash, instruction/data memory wait, multi-cycle MDU occupancy, wrong-path fetch drop, and a data-memory watchdog.

## Interface
Parameters:
- REG_W, 5, register index width
- MEM_TIMEOUT, 255, number of consecutive data-memory stall cycles that trips the watchdog

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- id_rs1, id_rs2  in  REG_W  source register indices in ID
- id_rs1_ren, id_rs2_ren  in  1  source register actually read
- ex_rd  in  REG_W  destination register in EX
- ex_rd_wen  in  1  EX instruction writes ex_rd
- ex_is_load  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- imem_ready  in  1  fetch response valid this cycle
- dmem_req, dmem_ready  in  1  MEM-stage access pending / completed
- mdu_start  in  1  one-cycle pulse, MDU op launched from EX
- mdu_done  in  1  one-cycle pulse, MDU result available
- stall_pc  out  1  hold PC
- stall_id_reg, invalid  out  1  IF/ID hold / IF/ID bubble
- stall_ex_reg, flush_ex_reg  out  1  ID/EX hold / bubble
- stall_mem_reg, flush_mem_reg  out  1  EX/MEM hold / bubble
- flush_wb_reg  out  1  MEM/WB bubble
- mem_timeout  out  1  sticky watchdog flag

## Operation
State registers:
- mdu_busy is set on mdu_start & ~mdu_done. It clears on mdu_done.
- drop_pending marks a wrong-path fetch in flight.
- wd_cnt is a saturating counter of width clog2(MEM_TIMEOUT+1).
- mem_timeout is sticky.

Combinational terms:
- mem_stall = dmem_req & ~dmem_ready
- mdu_stall = (mdu_start | mdu_busy) & ~mdu_done
- load_use = ex_is_load & ex_rd_wen & (ex_rd != 0) & ((id_rs1_ren & id_rs1 == ex_rd) | (id_rs2_ren & id_rs2 == ex_rd))
- redirect = ex_branch_taken & ~stall_ex_reg

Output equations, in priority order:
- stall_mem_reg = flush_wb_reg = mem_stall
- stall_ex_reg = mem_stall | mdu_stall
- flush_mem_reg = mdu_stall & ~mem_stall
- stall_id_reg = stall_ex_reg | (load_use & ~redirect)
- flush_ex_reg = ~stall_ex_reg & (redirect | load_use)
- stall_pc = stall_id_reg | (~imem_ready & ~redirect)
- invalid = ~stall_id_reg & (redirect | ~imem_ready | drop_pending)

Rules:
- invalid is never asserted together with stall_id_reg, because a hold wins in IF/ID.
- drop_pending is set on redirect & ~imem_ready. It clears on imem_ready & ~stall_id_reg & ~redirect. The returning stale instruction is bubbled in that cycle.
- drop_pending is held while a redirect & imem_ready cycle occurs.
- wd_cnt increments while mem_stall and clears when mem_stall is low.
- When wd_cnt reaches MEM_TIMEOUT, mem_timeout is set and wd_cnt saturates. mem_timeout has no effect on the stall outputs.

## Timing
- All stall/flush outputs are combinational on the current inputs and state (zero-cycle latency). They take effect at the next sys_clk edge in the pipeline registers.
- While sys_rst = 1, every output is 0. The reset edge clears mdu_busy, drop_pending, wd_cnt and mem_timeout, including mid-MDU-op or mid-memory-wait.
- Load-use inserts exactly one bubble. The next cycle the load is in MEM, and load_use is low unless a new load enters EX.
- A redirect during mem_stall or mdu_stall is deferred. EX is held, so ex_branch_taken persists, and the redirect fires in the first unstalled cycle.
- mdu_done in a mem_stall cycle: EX stays held by mem_stall and mdu_busy clears. The MDU holds its result.
- mdu_start & mdu_done in the same cycle: zero busy cycles.

## Configuration
- YSYX_22040383_MDU_EN defined: MDU tracking operates as described.
- Not defined: mdu_start and mdu_done remain as ports but are ignored. mdu_busy is removed, mdu_stall = 0 and flush_mem_reg = 0.

## Test plan
- ID reads x5, EX load writes x5 -> one cycle with stall_pc = stall_id_reg = flush_ex_reg = 1, then all 0. The same case with ex_rd = x0 -> no stall.
- Branch taken in EX with imem_ready = 1 -> invalid = flush_ex_reg = 1, stall_pc = 0 for one cycle.
- Branch taken with imem_ready = 0, then imem_ready = 1 three cycles later -> invalid on the redirect cycle and on the response cycle. drop_pending clears after the response.
- dmem_req high with dmem_ready low for 4 cycles, branch taken in EX -> stall_mem/ex/id/pc and flush_wb high for 4 cycles, invalid = 0. Redirect asserts in cycle 5.
- MDU_EN on, mdu_start then mdu_done 10 cycles later -> stall_ex_reg and flush_mem_reg high for 10 cycles. With MDU_EN off -> both stay 0.
- MEM_TIMEOUT = 8, dmem_ready held low 8 cycles -> mem_timeout rises after the 8th cycle and stays 1 until sys_rst.
